sft_seq: RTL and testbench

SFT_SEQ -- requirements
Module: sft_seq

---
 rtl/sft_seq.sv | 148 ++++++++++++++
 tb/tb_sft_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sft_seq.sv
// sft_seq: sequences a 74HC595-style shift stage. One request becomes an
// optional master reset, one shift strobe per byte (highest byte first), a
// store strobe and an output-enable strobe, then a one-cycle ack. Each shift
// and store waits for a completion pulse, bounded by a TMO-cycle timeout.
module sft_seq #(
  parameter logic [6:0] TMO = 7'd127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_nbyte,
  input  logic        req_clr,
  input  logic        req_oe,
  output logic        ack,
  output logic        err,
  output logic        sft_vld,
  output logic [1:0]  sft_cmd,
  output logic        sft_cmd_oen,
  output logic [7:0]  sft_din,
  input  logic        sft_done
);

  typedef enum logic [2:0] {
    IDLE, CLR, SHIFT, WAIT_SH, STORE, WAIT_ST, OE, FIN
  } state_t;

  localparam logic [1:0] CMD_MR    = 2'b00;
  localparam logic [1:0] CMD_SHIFT = 2'b01;
  localparam logic [1:0] CMD_STORE = 2'b10;
  localparam logic [1:0] CMD_OE    = 2'b11;

  state_t      state, state_nxt;
  logic [31:0] data_q;
  logic [1:0]  idx_q;      // index of the byte currently being shifted
  logic        clr_q;
  logic        oe_q;
  logic [6:0]  wait_cnt;
  logic        accept;
  logic        waiting;

  assign accept  = (state == IDLE) && req_vld;
  assign waiting = (state == WAIT_SH) || (state == WAIT_ST);

  // State register; reset drops straight back to IDLE without a clock edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request capture, byte index walk-down and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      idx_q    <= '0;
      clr_q    <= 1'b0;
      oe_q     <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (accept) begin
        data_q <= req_data;
        idx_q  <= req_nbyte;
        clr_q  <= req_clr;
        oe_q   <= req_oe;
      end
      if (state == WAIT_SH && sft_done && idx_q != 2'd0)
        idx_q <= idx_q - 2'd1;
      // Clearing during the strobe cycle makes the counter read 0 on the
      // first cycle of each wait state.
      if (state == SHIFT || state == STORE) wait_cnt <= '0;
      else if (waiting)                      wait_cnt <= wait_cnt + 7'd1;
    end
  end

  // Next-state and output decode; sft_done wins over a coincident timeout.
  // NOTE: every output and state_nxt gets a default first so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    req_rdy     = 1'b0;
    ack         = 1'b0;
    err         = 1'b0;
    sft_vld     = 1'b0;
    sft_cmd     = CMD_MR;
    sft_cmd_oen = 1'b0;
    sft_din     = 8'h00;
    unique case (state)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_vld) state_nxt = req_clr ? CLR : SHIFT;
      end
      CLR: begin
        sft_vld   = 1'b1;
        sft_cmd   = CMD_MR;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        sft_vld   = 1'b1;
        sft_cmd   = CMD_SHIFT;
        sft_din   = data_q[{idx_q, 3'b000} +: 8];
        state_nxt = WAIT_SH;
      end
      WAIT_SH: begin
        if (sft_done) begin
          state_nxt = (idx_q == 2'd0) ? STORE : SHIFT;
        end else if (wait_cnt == TMO) begin
          ack       = 1'b1;
          err       = 1'b1;
          state_nxt = IDLE;
        end
      end
      STORE: begin
        sft_vld   = 1'b1;
        sft_cmd   = CMD_STORE;
        state_nxt = WAIT_ST;
      end
      WAIT_ST: begin
        if (sft_done) begin
          state_nxt = OE;
        end else if (wait_cnt == TMO) begin
          ack       = 1'b1;
          err       = 1'b1;
          state_nxt = IDLE;
        end
      end
      OE: begin
        sft_vld     = 1'b1;
        sft_cmd     = CMD_OE;
        sft_cmd_oen = ~oe_q;
        state_nxt   = FIN;
      end
      FIN: begin
        ack       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The captured clear flag is only needed at acceptance; it is kept so the
  // whole request is visible in registers while a sequence runs.
  logic unused_clr;
  assign unused_clr = clr_q;

endmodule

// File: tb/tb_sft_seq.sv
// Testbench for sft_seq: a timeline model predicts every output on every
// cycle of a sequence from the request and the shift-stage response delay.
module tb_sft_seq;

  localparam logic [6:0] TMO = 7'd127;
  localparam int TMO_I = 127;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [31:0] req_data = '0;
  logic [1:0]  req_nbyte = '0;
  logic        req_clr = 1'b0;
  logic        req_oe = 1'b0;
  logic        ack, err, sft_vld, sft_cmd_oen;
  logic [1:0]  sft_cmd;
  logic [7:0]  sft_din;
  logic        sft_done;

  int n_tests = 0;
  int n_fail  = 0;

  sft_seq #(.TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_data(req_data),
    .req_nbyte(req_nbyte), .req_clr(req_clr), .req_oe(req_oe),
    .ack(ack), .err(err),
    .sft_vld(sft_vld), .sft_cmd(sft_cmd), .sft_cmd_oen(sft_cmd_oen),
    .sft_din(sft_din), .sft_done(sft_done)
  );

  always #5 clk = ~clk;

  // Cycle counter used by the shift-stage model.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shift-stage model: answers each shift/store strobe with a done pulse
  // done_dly cycles later; done_dly == 0 means it never answers.
  int   done_dly = 63;
  int   done_at  = -1;
  bit   flush = 1'b0;
  logic model_done = 1'b0;
  logic spur_done  = 1'b0;
  assign sft_done = model_done | spur_done;

  always @(negedge clk) begin
    model_done = (cyc == done_at);
    if (flush) done_at = -1;
    else if (sft_vld && (sft_cmd == 2'b01 || sft_cmd == 2'b10) && done_dly > 0)
      done_at = cyc + done_dly;
  end

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {rdy,ack,err,vld,cmd,oen,din}=%b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] observed();
    return {req_rdy, ack, err, sft_vld, sft_cmd, sft_cmd_oen, sft_din};
  endfunction

  localparam logic [14:0] IDLE_OUT = 15'h4000;

  // Total cycles from acceptance to the ack cycle.
  function automatic int seq_len(input int nb, input bit clr, input int d);
    int c = clr ? 1 : 0;
    if (d == 0) return 2 + c + TMO_I;
    return 2 + c + (nb + 1) * (d + 1) + (d + 1);
  endfunction

  // Expected outputs k cycles after acceptance (k = 0 is the acceptance cycle).
  function automatic logic [14:0] exp_out(input int k, input logic [31:0] data,
                                          input int nb, input bit clr, input bit oe,
                                          input int d);
    logic rdy = 1'b0, a = 1'b0, e = 1'b0, v = 1'b0, oen = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] din = 8'h00;
    int c = clr ? 1 : 0;
    int p = d + 1;
    int s = 1 + c + (nb + 1) * p;
    if (k == 0) rdy = 1'b1;
    else if (clr && k == 1) v = 1'b1;
    else if (d == 0) begin
      if (k == 1 + c) begin v = 1'b1; cmd = 2'b01; din = data[8*nb +: 8]; end
      else if (k == 2 + c + TMO_I) begin a = 1'b1; e = 1'b1; end
    end else begin
      for (int j = 0; j <= nb; j++)
        if (k == 1 + c + j * p) begin v = 1'b1; cmd = 2'b01; din = data[8*(nb-j) +: 8]; end
      if (k == s)          begin v = 1'b1; cmd = 2'b10; end
      else if (k == s + p) begin v = 1'b1; cmd = 2'b11; oen = ~oe; end
      else if (k == s + p + 1) a = 1'b1;
    end
    return {rdy, a, e, v, cmd, oen, din};
  endfunction

  // Issue one request on the next cycle and check every cycle up to the ack.
  // With keep set, req_vld stays high and the other request fields are
  // scrambled while busy; they must all be ignored.
  task automatic run_seq(input logic [31:0] data, input int nb, input bit clr,
                         input bit oe, input int d, input bit keep,
                         input int stop_at, input string tag);
    int len = seq_len(nb, clr, d);
    if (stop_at > 0) len = stop_at;
    @(negedge clk);
    done_dly  = d;
    req_data  = data;
    req_nbyte = nb[1:0];
    req_clr   = clr;
    req_oe    = oe;
    req_vld   = 1'b1;
    #1 check($sformatf("%s@0", tag), observed(), exp_out(0, data, nb, clr, oe, d));
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (keep) begin
        req_data  = $urandom;
        req_nbyte = 2'($urandom_range(0, 3));
        req_clr   = 1'($urandom_range(0, 1));
        req_oe    = 1'($urandom_range(0, 1));
      end else begin
        req_vld = 1'b0;
      end
      #1 check($sformatf("%s@%0d", tag, k), observed(), exp_out(k, data, nb, clr, oe, d));
    end
  endtask

  task automatic idle_cycles(input int n, input bit spur, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_vld   = 1'b0;
      spur_done = spur && (i % 2 == 0);
      #1 check($sformatf("%s@%0d", tag, i), observed(), IDLE_OUT);
    end
    spur_done = 1'b0;
  endtask

  initial begin
    // Reset state, checked while reset is still asserted.
    #12 check("reset", observed(), IDLE_OUT);
    @(negedge clk) rst = 1'b0;
    idle_cycles(3, 1'b0, "post_reset");

    // Single byte, nominal 64-cycle stage.
    run_seq(32'h0000_00A5, 0, 1'b0, 1'b1, 63, 1'b0, 0, "one_byte");
    // Four bytes with clear, highest byte first.
    run_seq(32'h1122_3344, 3, 1'b1, 1'b0, 63, 1'b0, 0, "four_clr");
    // Timeout: stage never answers.
    run_seq(32'h0000_005A, 1, 1'b0, 1'b1, 0, 1'b0, 0, "timeout");
    idle_cycles(2, 1'b0, "after_tmo");
    // Done on the terminal-count cycle wins over the timeout.
    run_seq(32'h0000_C33C, 1, 1'b0, 1'b1, TMO_I + 1, 1'b0, 0, "race");

    // Reset during WAIT_SH of a three-byte request.
    run_seq(32'h00AB_CDEF, 2, 1'b0, 1'b1, 63, 1'b0, 20, "pre_rst");
    #2 rst = 1'b1;
    flush = 1'b1;
    #1 check("rst_async", observed(), IDLE_OUT);
    @(negedge clk);
    rst   = 1'b0;
    flush = 1'b0;
    idle_cycles(4, 1'b0, "rst_idle");
    run_seq(32'h0000_7E81, 1, 1'b1, 1'b1, 10, 1'b0, 0, "after_rst");

    // Spurious done in IDLE, then back-to-back with req_vld held high.
    idle_cycles(6, 1'b1, "spur_idle");
    run_seq(32'hDEAD_BEEF, 2, 1'b0, 1'b0, 7, 1'b1, 0, "b2b_a");
    run_seq(32'h0BAD_F00D, 3, 1'b1, 1'b1, 5, 1'b0, 0, "b2b_b");

    // Randomized requests.
    for (int i = 0; i < 8; i++) begin
      int d = ($urandom_range(0, 3) == 0) ? 63 : int'($urandom_range(1, 20));
      run_seq($urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)), 0,
              $sformatf("rand%0d", i));
    end
    idle_cycles(2, 1'b0, "final_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
